// File: rtl/i2c_slave_regif_pkg.sv
// Shared types and constants for the I2C register-interface target.
package i2c_pkg;

    // Protocol FSM states of the target.
    typedef enum logic [3:0] {
        IDLE,
        DEVADDR,
        DEV_ACK,
        REGADDR,
        WR_ACK_WAIT,
        WRDATA,
        RD_LOAD,
        RDDATA,
        RD_ACK
    } state_t;

    // Meaning of the R/W bit in the address byte.
    localparam logic I2C_READ  = 1'b1;
    localparam logic I2C_WRITE = 1'b0;

    // True when the upper seven bits of an address byte select this target.
    function automatic logic addr_match(input logic [7:0] addr_byte, input logic [6:0] dev);
        return addr_byte[7:1] == dev;
    endfunction

endpackage

// File: rtl/i2c_slave_regif_if.sv
// Register-bank handshake between the I2C target and the register block.
interface i2c_slave_regif_if;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_wr;
    logic       reg_rd;
    logic [7:0] reg_rdata;

    // The I2C target issues accesses.
    modport master (
        output reg_addr, reg_wdata, reg_wr, reg_rd,
        input  reg_rdata
    );

    // The register block answers them.
    modport slave (
        input  reg_addr, reg_wdata, reg_wr, reg_rd,
        output reg_rdata
    );
endinterface

// File: rtl/i2c_slave_regif_line_cond.sv
// SCL/SDA conditioning: synchroniser, glitch filter, edge and START/STOP detection.
module i2c_line_cond #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    logic [1:0] raw;
    logic [1:0] filt;
    logic [1:0] prev;

    // Bit 0 carries SCL, bit 1 carries SDA.
    assign raw = {sda_in, scl_in};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_line
            logic [SYNC_STAGES-1:0] sync_reg;
            logic [CW-1:0]          cnt_reg;
            logic                   filt_reg;
            logic                   prev_reg;

            // Synchronise, then accept a new level only after FILT_LEN agreeing samples.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    sync_reg <= '1;
                    cnt_reg  <= '0;
                    filt_reg <= 1'b1;
                    prev_reg <= 1'b1;
                end else begin
                    sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw[gi]};
                    prev_reg <= filt_reg;
                    if (sync_reg[SYNC_STAGES-1] == filt_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == CW'(FILT_LEN - 1)) begin
                        filt_reg <= sync_reg[SYNC_STAGES-1];
                        cnt_reg  <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            end

            assign filt[gi] = filt_reg;
            assign prev[gi] = prev_reg;
        end
    endgenerate

    assign sda       = filt[1];
    assign scl_rise  =  filt[0] & ~prev[0];
    assign scl_fall  = ~filt[0] &  prev[0];
    // SDA may only move while SCL is high for a START or STOP.
    assign start_det = filt[0] & prev[0] &  prev[1] & ~filt[1];
    assign stop_det  = filt[0] & prev[0] & ~prev[1] &  filt[1];

endmodule

// File: rtl/i2c_slave_regif.sv
// I2C target with device-address decode, auto-incrementing register pointer
// and a single-cycle register-bank handshake.
module i2c_slave_regif
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = 7'h62,
    parameter int         NUM_REGS    = 16,
    parameter int         SYNC_STAGES = 2,
    parameter int         FILT_LEN    = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  scl_in,
    input  logic                  sda_in,
    output logic                  sda_oe,
    output logic                  busy,
    i2c_slave_regif_if.master     bus
);

    localparam int PW = $clog2(NUM_REGS);

    logic sda, scl_rise, scl_fall, start_det, stop_det;

    i2c_line_cond #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILT_LEN   (FILT_LEN)
    ) u_line_cond (
        .clk      (clk),
        .reset    (reset),
        .scl_in   (scl_in),
        .sda_in   (sda_in),
        .sda      (sda),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start_det(start_det),
        .stop_det (stop_det)
    );

    state_t          state_reg,     state_next;
    logic [3:0]      bit_cnt_reg,   bit_cnt_next;
    logic [7:0]      shift_reg,     shift_next;
    logic            rw_reg,        rw_next;
    logic            nack_reg,      nack_next;
    logic [PW-1:0]   ptr_reg,       ptr_next;
    logic            sda_oe_reg,    sda_oe_next;
    logic [7:0]      reg_addr_reg,  reg_addr_next;
    logic [7:0]      reg_wdata_reg, reg_wdata_next;
    logic            reg_wr_reg,    reg_wr_next;
    logic            reg_rd_reg,    reg_rd_next;
    logic            busy_reg,      busy_next;
    // [0]: strobe cycle in flight, [1]: bank data valid this cycle.
    logic [1:0]      ld_pipe_reg,   ld_pipe_next;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(NUM_REGS - 1)) ? '0 : p + 1'b1;
    endfunction

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            rw_reg        <= I2C_WRITE;
            nack_reg      <= 1'b0;
            ptr_reg       <= '0;
            sda_oe_reg    <= 1'b0;
            reg_addr_reg  <= '0;
            reg_wdata_reg <= '0;
            reg_wr_reg    <= 1'b0;
            reg_rd_reg    <= 1'b0;
            busy_reg      <= 1'b0;
            ld_pipe_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            bit_cnt_reg   <= bit_cnt_next;
            shift_reg     <= shift_next;
            rw_reg        <= rw_next;
            nack_reg      <= nack_next;
            ptr_reg       <= ptr_next;
            sda_oe_reg    <= sda_oe_next;
            reg_addr_reg  <= reg_addr_next;
            reg_wdata_reg <= reg_wdata_next;
            reg_wr_reg    <= reg_wr_next;
            reg_rd_reg    <= reg_rd_next;
            busy_reg      <= busy_next;
            ld_pipe_reg   <= ld_pipe_next;
        end
    end

    // Next-state and output decode; START/STOP take priority over every state.
    always_comb begin
        state_next     = state_reg;
        bit_cnt_next   = bit_cnt_reg;
        shift_next     = shift_reg;
        rw_next        = rw_reg;
        nack_next      = nack_reg;
        ptr_next       = ptr_reg;
        sda_oe_next    = sda_oe_reg;
        reg_addr_next  = reg_addr_reg;
        reg_wdata_next = reg_wdata_reg;
        reg_wr_next    = 1'b0;
        reg_rd_next    = 1'b0;
        busy_next      = busy_reg;
        ld_pipe_next   = {ld_pipe_reg[0], 1'b0};

        if (stop_det) begin
            state_next   = IDLE;
            sda_oe_next  = 1'b0;
            busy_next    = 1'b0;
            bit_cnt_next = '0;
            ld_pipe_next = '0;
        end else if (start_det) begin
            state_next   = DEVADDR;
            sda_oe_next  = 1'b0;
            busy_next    = 1'b1;
            bit_cnt_next = '0;
            ld_pipe_next = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    sda_oe_next = 1'b0;
                end
                DEVADDR: begin
                    if (scl_rise) begin
                        shift_next   = {shift_reg[6:0], sda};
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                    end else if (scl_fall && bit_cnt_reg == 4'd8) begin
                        bit_cnt_next = '0;
                        if (addr_match(shift_reg, DEV_ADDR)) begin
                            rw_next     = shift_reg[0];
                            sda_oe_next = 1'b1;
                            state_next  = DEV_ACK;
                        end else begin
                            state_next  = IDLE;
                        end
                    end
                end
                DEV_ACK: begin
                    // For reads the ACK stays driven until the first data bit is loaded.
                    if (scl_fall) begin
                        if (rw_reg == I2C_WRITE) begin
                            sda_oe_next = 1'b0;
                            state_next  = REGADDR;
                        end else begin
                            state_next  = RD_LOAD;
                        end
                    end
                end
                REGADDR: begin
                    if (scl_rise) begin
                        shift_next   = {shift_reg[6:0], sda};
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                    end else if (scl_fall && bit_cnt_reg == 4'd8) begin
                        bit_cnt_next = '0;
                        if ({1'b0, shift_reg} < 9'(NUM_REGS)) begin
                            ptr_next    = shift_reg[PW-1:0];
                            sda_oe_next = 1'b1;
                            state_next  = WR_ACK_WAIT;
                        end else begin
                            sda_oe_next = 1'b0;
                            state_next  = IDLE;
                        end
                    end
                end
                WR_ACK_WAIT: begin
                    if (scl_fall) begin
                        sda_oe_next  = 1'b0;
                        bit_cnt_next = '0;
                        state_next   = WRDATA;
                    end
                end
                WRDATA: begin
                    // bit_cnt 0..7 data bits, 8 = waiting to ACK, 9 = ACK bit on the bus.
                    if (scl_rise) begin
                        if (bit_cnt_reg < 4'd8) begin
                            shift_next   = {shift_reg[6:0], sda};
                            bit_cnt_next = bit_cnt_reg + 4'd1;
                            if (bit_cnt_reg == 4'd7) begin
                                reg_wr_next    = 1'b1;
                                reg_addr_next  = 8'(ptr_reg);
                                reg_wdata_next = {shift_reg[6:0], sda};
                            end
                        end
                    end else if (scl_fall) begin
                        if (bit_cnt_reg == 4'd8) begin
                            sda_oe_next  = 1'b1;
                            ptr_next     = ptr_inc(ptr_reg);
                            bit_cnt_next = 4'd9;
                        end else if (bit_cnt_reg == 4'd9) begin
                            sda_oe_next  = 1'b0;
                            bit_cnt_next = '0;
                        end
                    end
                end
                RD_LOAD: begin
                    reg_rd_next     = 1'b1;
                    reg_addr_next   = 8'(ptr_reg);
                    ld_pipe_next[0] = 1'b1;
                    bit_cnt_next    = '0;
                    state_next      = RDDATA;
                end
                RDDATA: begin
                    if (ld_pipe_reg[1]) begin
                        shift_next  = bus.reg_rdata;
                        sda_oe_next = ~bus.reg_rdata[7];
                        ptr_next    = ptr_inc(ptr_reg);
                    end else if (ld_pipe_reg == 2'b00 && scl_fall) begin
                        if (bit_cnt_reg == 4'd7) begin
                            sda_oe_next  = 1'b0;
                            bit_cnt_next = '0;
                            state_next   = RD_ACK;
                        end else begin
                            shift_next   = {shift_reg[6:0], 1'b0};
                            sda_oe_next  = ~shift_reg[6];
                            bit_cnt_next = bit_cnt_reg + 4'd1;
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        nack_next = sda;
                    end else if (scl_fall) begin
                        state_next = nack_reg ? IDLE : RD_LOAD;
                    end
                end
                default: begin
                    state_next  = IDLE;
                    sda_oe_next = 1'b0;
                end
            endcase
        end
    end

    assign sda_oe        = sda_oe_reg;
    assign busy          = busy_reg;
    assign bus.reg_addr  = reg_addr_reg;
    assign bus.reg_wdata = reg_wdata_reg;
    assign bus.reg_wr    = reg_wr_reg;
    assign bus.reg_rd    = reg_rd_reg;

endmodule

// File: tb/tb_i2c_slave_regif.sv
// Bench for i2c_slave_regif: bit-banged I2C master, read-only bank model,
// scoreboard queues for expected write and read strobes.
module tb_i2c_slave_regif;
    import i2c_pkg::*;

    localparam int Q = 12;   // clocks per quarter SCL period

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;
    logic sda_line;
    logic sda_oe;
    logic busy;

    i2c_slave_regif_if bus ();

    i2c_slave_regif #(
        .DEV_ADDR   (7'h62),
        .NUM_REGS   (16),
        .SYNC_STAGES(2),
        .FILT_LEN   (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .scl_in(scl_m),
        .sda_in(sda_line),
        .sda_oe(sda_oe),
        .busy  (busy),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Open-drain wired-AND of master and target.
    assign sda_line = sda_m & ~sda_oe;

    // Read-only bank with registered read.
    function automatic logic [7:0] bank_val(input logic [7:0] a);
        case (a)
            8'd1:    return 8'h11;
            8'd2:    return 8'h22;
            8'd3:    return 8'h33;
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge clk) begin
        if (bus.reg_rd) bus.reg_rdata <= bank_val(bus.reg_addr);
    end

    int n_checks = 0;
    int n_fail = 0;
    int n_extra_wr = 0;
    int n_extra_rd = 0;
    int n_both = 0;
    int oe_seen = 0;
    int txn = 0;
    logic [15:0] wr_q[$];
    logic [7:0]  rd_q[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, required 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor, sampled on the falling clock edge.
    always @(negedge clk) begin
        logic [15:0] e;
        if (reset) begin
            if (bus.reg_wr && bus.reg_rd) n_both++;
            if (sda_oe) oe_seen++;
            if (bus.reg_wr) begin
                if (wr_q.size() == 0) n_extra_wr++;
                else begin
                    e = wr_q.pop_front();
                    check_eq("wr_addr", 32'(bus.reg_addr), 32'(e[15:8]));
                    check_eq("wr_data", 32'(bus.reg_wdata), 32'(e[7:0]));
                end
            end
            if (bus.reg_rd) begin
                if (rd_q.size() == 0) n_extra_rd++;
                else check_eq("rd_addr", 32'(bus.reg_addr), 32'(rd_q.pop_front()));
            end
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1;
        wait_clks(Q);
        scl_m = 1'b1;
        wait_clks(2 * Q);
        sda_m = 1'b0;
        wait_clks(2 * Q);
        scl_m = 1'b0;
        wait_clks(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0;
        wait_clks(Q);
        scl_m = 1'b1;
        wait_clks(2 * Q);
        sda_m = 1'b1;
        wait_clks(4 * Q);
    endtask

    task automatic send_bit(input logic b);
        sda_m = b;
        wait_clks(Q);
        scl_m = 1'b1;
        wait_clks(2 * Q);
        scl_m = 1'b0;
        wait_clks(Q);
    endtask

    task automatic recv_bit(output logic b);
        sda_m = 1'b1;
        wait_clks(Q);
        scl_m = 1'b1;
        wait_clks(Q);
        b = sda_line;
        wait_clks(Q);
        scl_m = 1'b0;
        wait_clks(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        recv_bit(r);
        ack = ~r;
    endtask

    task automatic read_byte(output logic [7:0] d, input logic nack);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(r);
            d[i] = r;
        end
        send_bit(nack);
    endtask

    task automatic end_txn(input string name);
        txn++;
        check_eq("wr_pending", 32'(wr_q.size()), 32'd0);
        check_eq("rd_pending", 32'(rd_q.size()), 32'd0);
        check_eq("wr_extra", 32'(n_extra_wr), 32'd0);
        check_eq("rd_extra", 32'(n_extra_rd), 32'd0);
        check_eq("wr_rd_overlap", 32'(n_both), 32'd0);
        check_eq("busy_after_stop", 32'(busy), 32'd0);
        $display("txn %0d: %s done (checks=%0d)", txn, name, n_checks);
    endtask

    initial begin
        #200_000_00;
        $display("FAIL watchdog: simulation did not finish, observed timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ack;
        logic [7:0] d;
        logic [7:0] rd_exp[3];
        rd_exp[0] = 8'h11; rd_exp[1] = 8'h22; rd_exp[2] = 8'h33;

        // Reset values
        wait_clks(5);
        check_eq("rst_sda_oe", 32'(sda_oe), 32'd0);
        check_eq("rst_reg_wr", 32'(bus.reg_wr), 32'd0);
        check_eq("rst_reg_rd", 32'(bus.reg_rd), 32'd0);
        check_eq("rst_reg_addr", 32'(bus.reg_addr), 32'd0);
        check_eq("rst_reg_wdata", 32'(bus.reg_wdata), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        wait_clks(20);

        // Write index 3, data A5, 5A
        i2c_start();
        check_eq("busy_after_start", 32'(busy), 32'd1);
        write_byte(8'hC4, ack); check_eq("t1_dev_ack", 32'(ack), 32'd1);
        write_byte(8'h03, ack); check_eq("t1_idx_ack", 32'(ack), 32'd1);
        wr_q.push_back({8'd3, 8'hA5});
        write_byte(8'hA5, ack); check_eq("t1_d0_ack", 32'(ack), 32'd1);
        wr_q.push_back({8'd4, 8'h5A});
        write_byte(8'h5A, ack); check_eq("t1_d1_ack", 32'(ack), 32'd1);
        i2c_stop();
        end_txn("write idx3 A5 5A");

        // Foreign address: never acknowledged, never driven
        oe_seen = 0;
        i2c_start();
        write_byte(8'h50, ack); check_eq("t2_dev_nack", 32'(ack), 32'd0);
        write_byte(8'h03, ack); check_eq("t2_byte_nack", 32'(ack), 32'd0);
        i2c_stop();
        check_eq("t2_oe_cycles", 32'(oe_seen), 32'd0);
        end_txn("foreign address 0x28");

        // Write index 1, repeated START, read three bytes
        i2c_start();
        write_byte(8'hC4, ack); check_eq("t3_dev_ack", 32'(ack), 32'd1);
        write_byte(8'h01, ack); check_eq("t3_idx_ack", 32'(ack), 32'd1);
        i2c_start();
        rd_q.push_back(8'd1); rd_q.push_back(8'd2); rd_q.push_back(8'd3);
        write_byte(8'hC5, ack); check_eq("t3_rd_ack", 32'(ack), 32'd1);
        for (int i = 0; i < 3; i++) begin
            read_byte(d, (i == 2));
            check_eq($sformatf("t3_rdata%0d", i), 32'(d), 32'(rd_exp[i]));
        end
        check_eq("t3_oe_after_nack", 32'(sda_oe), 32'd0);
        i2c_stop();
        end_txn("write idx1, Sr, read 3");

        // Pointer wrap at the last register
        i2c_start();
        write_byte(8'hC4, ack); check_eq("t4_dev_ack", 32'(ack), 32'd1);
        write_byte(8'h0F, ack); check_eq("t4_idx_ack", 32'(ack), 32'd1);
        wr_q.push_back({8'd15, 8'hC3});
        write_byte(8'hC3, ack); check_eq("t4_d0_ack", 32'(ack), 32'd1);
        wr_q.push_back({8'd0, 8'h3C});
        write_byte(8'h3C, ack); check_eq("t4_d1_ack", 32'(ack), 32'd1);
        i2c_stop();
        end_txn("wrap write idx15 C3 3C");

        // Out-of-range index is refused
        i2c_start();
        write_byte(8'hC4, ack); check_eq("t4b_dev_ack", 32'(ack), 32'd1);
        write_byte(8'h10, ack); check_eq("t4b_idx_nack", 32'(ack), 32'd0);
        i2c_stop();
        end_txn("index 0x10 refused");

        // STOP after five data bits
        i2c_start();
        write_byte(8'hC4, ack); check_eq("t5_dev_ack", 32'(ack), 32'd1);
        write_byte(8'h05, ack); check_eq("t5_idx_ack", 32'(ack), 32'd1);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        i2c_stop();
        check_eq("t5_state", 32'(dut.state_reg), 32'(IDLE));
        check_eq("t5_sda_oe", 32'(sda_oe), 32'd0);
        end_txn("stop mid-byte");

        // Point at register 7 (reads back 0x00), then reset mid-read
        i2c_start();
        write_byte(8'hC4, ack); check_eq("t6_dev_ack", 32'(ack), 32'd1);
        write_byte(8'h07, ack); check_eq("t6_idx_ack", 32'(ack), 32'd1);
        i2c_stop();
        i2c_start();
        rd_q.push_back(8'd7);
        write_byte(8'hC5, ack); check_eq("t6_rd_ack", 32'(ack), 32'd1);
        for (int i = 0; i < 3; i++) recv_bit(ack);
        check_eq("t6_oe_before_rst", 32'(sda_oe), 32'd1);
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check_eq("t6_rst_sda_oe", 32'(sda_oe), 32'd0);
        check_eq("t6_rst_busy", 32'(busy), 32'd0);
        check_eq("t6_rst_reg_addr", 32'(bus.reg_addr), 32'd0);
        check_eq("t6_rst_reg_rd", 32'(bus.reg_rd), 32'd0);
        scl_m = 1'b1;
        sda_m = 1'b1;
        wait_clks(10);
        reset = 1'b1;
        wait_clks(20);
        end_txn("reset during read");

        // Normal traffic after reset
        i2c_start();
        write_byte(8'hC4, ack); check_eq("t7_dev_ack", 32'(ack), 32'd1);
        write_byte(8'h02, ack); check_eq("t7_idx_ack", 32'(ack), 32'd1);
        wr_q.push_back({8'd2, 8'h77});
        write_byte(8'h77, ack); check_eq("t7_d0_ack", 32'(ack), 32'd1);
        i2c_stop();
        end_txn("write after reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
